// File: rtl/ifu_pkg.sv
// ifu_pkg: shared widths, instruction size and prefetch entry layout for the fetch unit
package ifu_pkg;
  localparam int DEF_XLEN    = 64;
  localparam int DEF_ILEN    = 32;
  localparam int INSTR_BYTES = 4;
  typedef struct packed {
    logic [DEF_XLEN-1:0] pc;
    logic [DEF_ILEN-1:0] instr;
    logic                filled;
  } fetch_entry_t;
endpackage

// File: rtl/ifu_fetch_buf.sv
// ifu_fetch_buf: circular prefetch buffer; slots allocated at request, filled in order at response, popped at head
//   i_clk, i_rst_n        clock, async active-low reset
//   i_flush               drop every entry and rewind all pointers
//   i_alloc, i_alloc_pc   claim the tail slot for a newly issued request
//   i_fill, i_fill_data   write the oldest unfilled slot with a returned instruction
//   i_pop                 retire the head slot
//   o_count, o_pend       allocated entries / allocated-but-unfilled entries
//   o_head_*              head entry, valid only when allocated and filled
module ifu_fetch_buf import ifu_pkg::*; #(
  parameter int XLEN  = DEF_XLEN,
  parameter int ILEN  = DEF_ILEN,
  parameter int DEPTH = 4
)(
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic                       i_flush,
  input  logic                       i_alloc,
  input  logic [XLEN-1:0]            i_alloc_pc,
  input  logic                       i_fill,
  input  logic [ILEN-1:0]            i_fill_data,
  input  logic                       i_pop,
  output logic [$clog2(DEPTH):0]     o_count,
  output logic [$clog2(DEPTH):0]     o_pend,
  output logic                       o_head_valid,
  output logic [XLEN-1:0]            o_head_pc,
  output logic [ILEN-1:0]            o_head_instr
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [AW-1:0]    r_head, r_tail, r_fill;
  logic [CW-1:0]    r_count, r_pend;
  logic [DEPTH-1:0] r_filled;
  logic [XLEN-1:0]  r_pc    [DEPTH];
  logic [ILEN-1:0]  r_instr [DEPTH];
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      r_head   <= '0;
      r_tail   <= '0;
      r_fill   <= '0;
      r_count  <= '0;
      r_pend   <= '0;
      r_filled <= '0;
    end else if (i_flush) begin
      r_head   <= '0;
      r_tail   <= '0;
      r_fill   <= '0;
      r_count  <= '0;
      r_pend   <= '0;
      r_filled <= '0;
    end else begin
      if (i_alloc) r_filled[r_tail] <= 1'b0;
      if (i_alloc) r_tail <= r_tail + AW'(1);
      if (i_fill) r_filled[r_fill] <= 1'b1;
      if (i_fill) r_fill <= r_fill + AW'(1);
      if (i_pop) r_head <= r_head + AW'(1);
      r_count <= r_count + CW'(i_alloc) - CW'(i_pop);
      r_pend  <= r_pend + CW'(i_alloc) - CW'(i_fill);
    end
  always_ff @(posedge i_clk) begin
    if (i_alloc) r_pc[r_tail] <= i_alloc_pc;
    if (i_fill) r_instr[r_fill] <= i_fill_data;
  end
  // a popped slot keeps its filled bit, so an empty buffer must not trust it
  assign o_head_valid = (r_count != '0) && r_filled[r_head];
  assign o_head_pc    = r_pc[r_head];
  assign o_head_instr = r_instr[r_head];
  assign o_count      = r_count;
  assign o_pend       = r_pend;
endmodule

// File: rtl/ifu_prefetch.sv
// ifu_prefetch: sequential-PC fetch unit with prefetch buffer, redirect flush and stale-response dropping
//   clk, reset (async, active-low), boot_pc (fetch start while in reset)
//   redirect_valid/redirect_pc        restart fetch at a word-aligned target, flushing the buffer
//   imem_req_valid/ready/addr         pipelined instruction memory requests
//   imem_rsp_valid/data               in-order responses, no backpressure
//   out_valid/ready/pc/pc_plus4/instr instruction handoff to decode
//   Optional IFU_PERF_CNT_EN adds perf_fetched (handshakes) and perf_stall (decode starved cycles).
module ifu_prefetch import ifu_pkg::*; #(
  parameter int XLEN  = DEF_XLEN,
  parameter int ILEN  = DEF_ILEN,
  parameter int DEPTH = 4
)(
  input  logic            clk,
  input  logic            reset,
  input  logic [XLEN-1:0] boot_pc,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [ILEN-1:0] imem_rsp_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] out_pc_plus4,
  output logic [ILEN-1:0] out_instr
`ifdef IFU_PERF_CNT_EN
  ,output logic [31:0]    perf_fetched,
  output logic [31:0]     perf_stall
`endif
);
  localparam int CW = $clog2(DEPTH) + 1;
  // headroom so back-to-back redirects can stack outstanding drops
  localparam int DW = CW + 8;
  logic [XLEN-1:0] r_fetch_pc;
  logic [DW-1:0]   r_drop, w_total;
  logic [CW-1:0]   w_count, w_pend;
  logic            w_head_valid, w_req, w_fill, w_pop;
  logic [XLEN-1:0] w_head_pc;
  logic [ILEN-1:0] w_head_instr;
  ifu_fetch_buf #(.XLEN(XLEN), .ILEN(ILEN), .DEPTH(DEPTH)) u_buf (
    .i_clk(clk), .i_rst_n(reset), .i_flush(redirect_valid),
    .i_alloc(w_req), .i_alloc_pc(r_fetch_pc),
    .i_fill(w_fill), .i_fill_data(imem_rsp_data),
    .i_pop(w_pop), .o_count(w_count), .o_pend(w_pend),
    .o_head_valid(w_head_valid), .o_head_pc(w_head_pc), .o_head_instr(w_head_instr)
  );
  // request gating uses the pre-pop count: no same-cycle bypass when full
  assign imem_req_valid = reset && !redirect_valid && (w_count < CW'(DEPTH));
  assign imem_req_addr  = r_fetch_pc;
  assign w_req          = imem_req_valid && imem_req_ready;
  assign w_fill         = imem_rsp_valid && !redirect_valid && (r_drop == '0) && (w_pend != '0);
  assign w_pop          = w_head_valid && out_ready && !redirect_valid;
  assign w_total        = r_drop + DW'(w_pend);
  assign out_valid      = w_head_valid;
  assign out_pc         = w_head_valid ? w_head_pc : '0;
  assign out_pc_plus4   = w_head_valid ? w_head_pc + XLEN'(INSTR_BYTES) : '0;
  assign out_instr      = w_head_valid ? w_head_instr : '0;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      r_fetch_pc <= boot_pc;
      r_drop     <= '0;
    end else if (redirect_valid) begin
      r_fetch_pc <= redirect_pc & ~XLEN'(3);
      // a response landing this cycle retires one of the outstanding requests now
      r_drop     <= w_total - DW'(imem_rsp_valid && (w_total != '0));
    end else begin
      if (w_req) r_fetch_pc <= r_fetch_pc + XLEN'(INSTR_BYTES);
      if (imem_rsp_valid && (r_drop != '0)) r_drop <= r_drop - DW'(1);
    end
  assert property (@(posedge clk) disable iff (!reset)
    imem_rsp_valid |-> ((r_drop != '0) || (w_pend != '0)));
`ifdef IFU_PERF_CNT_EN
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      perf_fetched <= '0;
      perf_stall   <= '0;
    end else begin
      if (out_valid && out_ready) perf_fetched <= perf_fetched + 32'd1;
      if (out_ready && !out_valid) perf_stall <= perf_stall + 32'd1;
    end
`endif
endmodule

// File: tb/tb_ifu_prefetch.sv
// tb_ifu_prefetch: transaction-level model and directed scenarios for ifu_prefetch
module tb_ifu_prefetch;
  localparam int DEPTH = 4;
  logic        clk = 0, reset = 0, redirect_valid = 0, imem_req_ready = 0, imem_rsp_valid = 0, out_ready = 0;
  logic [63:0] boot_pc = 0, redirect_pc = 0;
  logic [31:0] imem_rsp_data = 0;
  logic        imem_req_valid, out_valid;
  logic [63:0] imem_req_addr, out_pc, out_pc_plus4;
  logic [31:0] out_instr;
`ifdef IFU_PERF_CNT_EN
  logic [31:0] perf_fetched, perf_stall;
  int          m_fetched = 0, m_stall = 0;
`endif
  int          checks = 0, errors = 0, lat = 1, cyc = 0, rdy = 0;
  logic [63:0] live_q[$], mem_addr[$];
  int          mem_due[$];
  bit          mem_live[$];
  logic [63:0] m_req_pc = 0;
  logic [47:0] pat_o = 48'hF3D7_B5E9_6CAF, pat_r = 48'hFEDB_7F6D_DF7B;

  always #5 clk = ~clk;

  ifu_prefetch #(.XLEN(64), .ILEN(32), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .boot_pc(boot_pc),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_pc_plus4(out_pc_plus4), .out_instr(out_instr)
`ifdef IFU_PERF_CNT_EN
    , .perf_fetched(perf_fetched), .perf_stall(perf_stall)
`endif
  );

  function automatic logic [31:0] mem_word(input logic [63:0] a);
    return a[31:0] ^ a[63:32] ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // memory: returns each accepted request lat cycles later, in order
  always @(posedge clk) begin
    cyc++;
    #1;
    if (mem_addr.size() != 0 && mem_due[0] <= cyc) begin
      imem_rsp_valid = 1;
      imem_rsp_data  = mem_word(mem_addr[0]);
    end else begin
      imem_rsp_valid = 0;
      imem_rsp_data  = 0;
    end
  end

  // reference: live_q holds PCs of requests still owed to decode, rdy how many of them have returned
  always @(negedge clk) begin
    bit exp_rv, ov;
    if (!reset) begin
      chk("rst_req_valid", imem_req_valid, 0);
      chk("rst_req_addr", imem_req_addr, boot_pc);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_pc", out_pc, 0);
      chk("rst_out_plus4", out_pc_plus4, 0);
      chk("rst_out_instr", out_instr, 0);
      live_q.delete(); mem_addr.delete(); mem_due.delete(); mem_live.delete();
      rdy = 0;
      m_req_pc = boot_pc;
`ifdef IFU_PERF_CNT_EN
      chk("rst_perf_fetched", perf_fetched, 0);
      chk("rst_perf_stall", perf_stall, 0);
      m_fetched = 0; m_stall = 0;
`endif
    end else begin
      exp_rv = !redirect_valid && live_q.size() < DEPTH;
      ov = rdy > 0;
      chk("req_valid", imem_req_valid, exp_rv);
      if (exp_rv) chk("req_addr", imem_req_addr, m_req_pc);
      chk("out_valid", out_valid, ov);
      if (ov) begin
        chk("out_pc", out_pc, live_q[0]);
        chk("out_pc_plus4", out_pc_plus4, live_q[0] + 64'd4);
        chk("out_instr", out_instr, mem_word(live_q[0]));
      end else begin
        chk("idle_out_pc", out_pc, 0);
        chk("idle_out_instr", out_instr, 0);
      end
`ifdef IFU_PERF_CNT_EN
      chk("perf_fetched", perf_fetched, m_fetched);
      chk("perf_stall", perf_stall, m_stall);
      if (ov && out_ready) m_fetched++;
      if (!ov && out_ready) m_stall++;
`endif
      if (imem_rsp_valid && mem_addr.size() != 0) begin
        if (mem_live[0] && !redirect_valid) rdy++;
        void'(mem_addr.pop_front()); void'(mem_due.pop_front()); void'(mem_live.pop_front());
      end
      if (redirect_valid) begin
        foreach (mem_live[i]) mem_live[i] = 0;
        live_q.delete();
        rdy = 0;
        m_req_pc = {redirect_pc[63:2], 2'b00};
      end else begin
        if (ov && out_ready) begin void'(live_q.pop_front()); rdy--; end
        if (exp_rv && imem_req_ready) begin
          live_q.push_back(m_req_pc);
          mem_addr.push_back(m_req_pc); mem_due.push_back(cyc + lat); mem_live.push_back(1);
          m_req_pc += 64'd4;
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_ov(input string name);
    int n = 0;
    do begin sample(); n++; end while (!out_valid && n < 60);
    chk(name, out_valid, 1);
  endtask

  task automatic do_reset(input logic [63:0] b, input int l, input logic ordy, input logic rr);
    reset = 0; boot_pc = b; lat = l; out_ready = ordy; imem_req_ready = rr; redirect_valid = 0;
    tick(3);
    reset = 1;
  endtask

  initial begin
    int nreq;
    // 1: sequential stream, latency 1
    do_reset(64'h1000, 1, 1, 1);
    wait_ov("t1_first_valid");
    chk("t1_pc0", out_pc, 64'h1000);
    chk("t1_p4_0", out_pc_plus4, 64'h1004);
    sample(); chk("t1_v1", out_valid, 1); chk("t1_pc1", out_pc, 64'h1004);
    sample(); chk("t1_pc2", out_pc, 64'h1008); chk("t1_p4_2", out_pc_plus4, 64'h100C);
    // 2: decode stalled, buffer fills to DEPTH
    do_reset(64'h1000, 1, 0, 1);
    nreq = 0;
    for (int i = 0; i < 12; i++) begin
      sample();
      if (imem_req_valid && imem_req_ready) nreq++;
    end
    chk("t2_req_count", nreq, 4);
    chk("t2_req_blocked", imem_req_valid, 0);
    chk("t2_head_pc", out_pc, 64'h1000);
    tick(1); out_ready = 1;
    sample(); chk("t2_first_pc", out_pc, 64'h1000);
    for (int i = 0; i < 8; i++) begin
      sample();
      chk("t2_stream_pc", out_pc, 64'h1004 + 64'(4 * i));
      if (i == 0) chk("t2_req_after_pop", imem_req_valid, 1);
    end
    // 3: redirect with three requests in flight, latency 3
    do_reset(64'h1000, 3, 0, 1);
    tick(3);
    imem_req_ready = 0; redirect_valid = 1; redirect_pc = 64'h2002;
    tick(1);
    redirect_valid = 0; imem_req_ready = 1; out_ready = 1;
    wait_ov("t3_valid");
    chk("t3_pc", out_pc, 64'h2000);
    chk("t3_instr", out_instr, 32'h1357_BBDF);
    wait_ov("t3_valid2");
    chk("t3_pc2", out_pc, 64'h2004);
    // 3b: second redirect while drops are still pending
    tick(1); redirect_valid = 1; redirect_pc = 64'h3001;
    tick(1); redirect_valid = 0;
    tick(1); redirect_valid = 1; redirect_pc = 64'h4000;
    tick(1); redirect_valid = 0;
    wait_ov("t3b_valid");
    chk("t3b_pc", out_pc, 64'h4000);
    // 4: PC wraps at 2^64
    do_reset(64'hFFFF_FFFF_FFFF_FFFC, 1, 1, 1);
    wait_ov("t4_valid");
    chk("t4_pc0", out_pc, 64'hFFFF_FFFF_FFFF_FFFC);
    chk("t4_p4_0", out_pc_plus4, 64'h0);
    sample();
    chk("t4_pc1", out_pc, 64'h0);
    chk("t4_p4_1", out_pc_plus4, 64'h4);
    // 5: asynchronous reset mid-stream
    do_reset(64'h1000, 2, 1, 1);
    wait_ov("t5_valid");
    #2 reset = 0; boot_pc = 64'h5000;
    #1;
    chk("t5_async_out_valid", out_valid, 0);
    chk("t5_async_req_valid", imem_req_valid, 0);
    chk("t5_async_out_pc", out_pc, 0);
    tick(2); reset = 1;
    sample();
    chk("t5_restart_req", imem_req_valid, 1);
    chk("t5_restart_addr", imem_req_addr, 64'h5000);
    wait_ov("t5_valid2");
    chk("t5_restart_pc", out_pc, 64'h5000);
    // 7: mixed ready patterns with back-to-back and later redirects
    do_reset(64'h8000, 2, 0, 1);
    for (int i = 0; i < 48; i++) begin
      out_ready = pat_o[i]; imem_req_ready = pat_r[i];
      redirect_valid = (i == 20 || i == 21 || i == 33);
      redirect_pc = 64'h9000 + 64'(i);
      tick(1);
    end
    redirect_valid = 0; out_ready = 1; imem_req_ready = 1;
    tick(10);
`ifdef IFU_PERF_CNT_EN
    // 6: 10 handshakes, 3 starved cycles
    do_reset(64'h1000, 1, 0, 1);
    tick(10);
    imem_req_ready = 0; out_ready = 1; tick(7);
    out_ready = 0; imem_req_ready = 1; tick(10);
    imem_req_ready = 0; out_ready = 1; tick(4);
    out_ready = 0; imem_req_ready = 1; tick(10);
    imem_req_ready = 0; out_ready = 1; tick(2);
    out_ready = 0;
    sample();
    chk("t6_perf_fetched", perf_fetched, 10);
    chk("t6_perf_stall", perf_stall, 3);
`endif
    tick(3);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
